// File: rtl/mips_cpu_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips_cpu_fetch_unit
//
// Instruction-fetch stage of the multi-cycle MIPS core. Owns the program
// counter, performs a handshaked word read on the memory bus, and hands the
// fetched word plus a one-cycle capture strobe to the instruction register.
// On command from the control unit it loads the next PC (sequential, branch,
// jump or register-jump). It also detects the halt condition (PC becomes 0)
// and misaligned register-jump targets.
//
// Ports
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   fetch_req      : start a fetch from the current PC (accepted in IDLE only)
//   pc_update      : strobe, load the next PC chosen by pc_sel (IDLE only)
//   pc_sel         : 0 pc+4, 1 branch, 2 jump, 3 register (jr)
//   branch_offset  : 16-bit branch immediate (word offset, signed)
//   jmp_address    : 26-bit jump field
//   jr_target      : register value for jr/jalr
//   address, read  : memory request (address = pc, meaningful when read=1)
//   waitrequest    : memory stall; read completes when read=1 and waitrequest=0
//   readdata       : memory read data, valid on the completing cycle
//   instr_word     : registered fetched word
//   ir_enable      : one-cycle strobe for the instruction register
//   pc, pc_plus4   : current PC and its link value pc+4
//   busy           : fetch in flight (REQ or DONE)
//   active         : low once halted
//   misaligned     : sticky, a jr target had nonzero bits [1:0]
// -----------------------------------------------------------------------------
module mips_cpu_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        pc_update,
  input  logic [1:0]  pc_sel,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jmp_address,
  input  logic [31:0] jr_target,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] instr_word,
  output logic        ir_enable,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        active,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_r;

  logic [31:0] cand_pc;
  logic        accept;
  logic        jr_bad;
  logic        upd_ok;
  logic        halt_now;

  // Branch target: base + sign_extend(offset) * 4, wrapping mod 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0]        base,
                                                input logic signed [15:0] off);
    logic signed [31:0] disp;
    disp = {{14{off[15]}}, off, 2'b00};
    return base + $unsigned(disp);
  endfunction

  // Jump target stays inside the 256 MB region of the delay-slot PC.
  function automatic logic [31:0] jump_target(input logic [31:0] base,
                                              input logic [25:0] field);
    return {base[31:28], field, 2'b00};
  endfunction

  assign pc       = pc_r;
  assign pc_plus4 = pc_r + 32'd4;
  assign address  = pc_r;

  always_comb begin
    cand_pc = pc_plus4;
    case (pc_sel)
      2'd0:    cand_pc = pc_plus4;
      2'd1:    cand_pc = branch_target(pc_plus4, $signed(branch_offset));
      2'd2:    cand_pc = jump_target(pc_plus4, jmp_address);
      default: cand_pc = jr_target;
    endcase
  end

  // A misaligned jr is accepted (it sets the sticky flag) but leaves pc alone,
  // so it can never trigger a halt either.
  assign accept   = (state == IDLE) && pc_update;
  assign jr_bad   = (pc_sel == 2'd3) && (jr_target[1:0] != 2'b00);
  assign upd_ok   = accept && !jr_bad;
  assign halt_now = upd_ok && (cand_pc == 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_r       <= RESET_VECTOR;
      instr_word <= 32'h0;
      read       <= 1'b0;
      ir_enable  <= 1'b0;
      busy       <= 1'b0;
      active     <= 1'b1;
      misaligned <= 1'b0;
    end else begin
      ir_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (upd_ok) begin
            pc_r <= cand_pc;
          end
          if (accept && jr_bad) begin
            misaligned <= 1'b1;
          end
          // A halting update beats a simultaneous fetch request; otherwise the
          // fetch reads from the freshly updated PC.
          if (halt_now) begin
            state  <= HALTED;
            active <= 1'b0;
          end else if (fetch_req) begin
            state <= REQ;
            read  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          if (!waitrequest) begin
            instr_word <= readdata;
            read       <= 1'b0;
            ir_enable  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
